piso_serializer_tx: RTL
=======================

// Module: piso_serializer_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: takes a WIDTH-bit word through a valid/ready load
//  handshake, then shifts it out one bit per shift_en strobe.
//  Transmit-side counterpart to the latch/register capture cells in the W7 storage set.
//  Feeds a serial link or a bit-serial consumer driving shift_en.
// PARAMETERS
//  WIDTH      8   data word width in bits; legal range >= 2
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk        in   1      single clock, rising-edge active
//  reset_n    in   1      asynchronous, active-low reset
//  load_valid in   1      load_data is valid
//  load_ready out  1      block can accept a word (IDLE)
//  load_data  in   WIDTH  parallel word to transmit
//  shift_en   in   1      consumer takes current ser_out bit this cycle
//  ser_out    out  1      current serial bit
//  ser_valid  out  1      ser_out holds a valid bit (SHIFT)
//  busy       out  1      word in flight (equals ser_valid)
//  done       out  1      one-cycle pulse after last bit taken
// BEHAVIOUR
//  Reset (reset_n=0, async, any state): state=IDLE, shift_reg=0, bit_cnt=0, load_ready=1,
//   ser_out=0, ser_valid=0, busy=0, done=0; any in-flight word is discarded, no done pulse.
//  FSM states: IDLE, SHIFT.
//  IDLE: load_ready=1, ser_valid=0, ser_out=0; shift_en ignored.
//   load_valid=1 at edge -> shift_reg<=load_data, bit_cnt<=WIDTH, state<=SHIFT.
//  SHIFT: load_ready=0, load_valid ignored (no capture, no overwrite), ser_valid=1.
//   ser_out = shift_reg[WIDTH-1] if MSB_FIRST else shift_reg[0]; combinational from reg.
//   shift_en=1 at edge -> shift toward the output end, zero-fill; bit_cnt<=bit_cnt-1.
//   shift_en=1 with bit_cnt==1 -> state<=IDLE, done<=1 for exactly one cycle.
//   shift_en=0 -> hold everything; no timeout.
//  Latency: word captured at edge N; first bit visible after edge N; with shift_en held
//   high, last bit taken at edge N+WIDTH; done=1 and load_ready=1 in cycle after that edge.
//  Back-to-back: next load accepted in the done cycle (IDLE); minimum one-cycle gap
//   between last bit and first bit of next word; no bypass from load_data to ser_out.
//  done is registered and is never asserted in the same cycle as ser_valid.
//  bit_cnt width = $clog2(WIDTH+1); never wraps (decrement only in SHIFT with bit_cnt>=1).
//  shift_en and load_valid both high: IDLE -> load only; SHIFT -> shift only.
// STRUCTURE
//  Package piso_serializer_pkg: state typedef (IDLE=1'b0, SHIFT=1'b1).
//  Sub-module dff_en_cell (d, en, clk, reset_n, q): enable D flip-flop with async
//   active-low clear; WIDTH instances form shift_reg; per-bit mux selects load vs shift.
//  FSM, bit counter and done register live in the top module.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles -> load_ready=1, ser_valid=0, ser_out=0, done=0.
//  2 WIDTH=8, MSB_FIRST=1, load 8'hA5, shift_en=1 constant -> ser_out 1,0,1,0,0,1,0,1;
//    done=1 exactly one cycle after 8th shift.
//  3 MSB_FIRST=0, load 8'h01, shift_en toggled 1,0,1,0... -> bits 1 then seven 0s,
//    each held while shift_en=0; 16 cycles to done.
//  4 In SHIFT, load_valid=1 with 8'hFF -> load_ready=0, no capture, original bits intact.
//  5 Reset_n pulsed low after 3 bits of 8'h3C -> immediate IDLE, ser_out=0, no done;
//    reload 8'hC3 -> full 8 bits correct.
//  6 Back-to-back 8'hF0 then 8'h0F, load_valid held high -> second word accepted in done
//    cycle; serial stream F0 then 0F with one idle (ser_valid=0) cycle between.

Source files
------------

// File: rtl/piso_serializer_tx_pkg.sv
// Shared state encoding for the parallel-in/serial-out transmitter.
// Plain logic constants keep the encoding visible in legacy waveform tools.
package piso_serializer_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

endpackage

// File: rtl/piso_serializer_tx_if.sv
// Load handshake and serial-side signals of the transmitter.
// The master drives the load word and shift strobe. The slave is the serializer.
interface piso_serializer_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, ser_out, ser_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, ser_out, ser_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer_tx_dff_en_cell.sv
// Enable D flip-flop with async active-low clear. This is one bit of the shift register.
// Latency: q follows d one edge after en. When en is low, q holds its value.
module dff_en_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    input  logic en,
    output logic q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= 1'b0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/piso_serializer_tx.sv
// Serializes a WIDTH-bit word loaded over valid/ready, one bit per shift_en strobe.
// Latency: the first bit is visible the cycle after load. done pulses the cycle after the last bit is taken.
// Backpressure: load_ready drops while a word is in flight. shift_en low holds the current bit indefinitely.
module piso_serializer_tx
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    piso_serializer_tx_if.slave  io
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic             done_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] shift_d;
    logic             load_fire;
    logic             shift_fire;
    logic             reg_en;

    assign load_fire  = (state == IDLE)  && io.load_valid;
    assign shift_fire = (state == SHIFT) && io.shift_en;
    assign reg_en     = load_fire || shift_fire;

    // Shift toward the output end and fill the vacated bit with zero.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST)
            shifted = {shift_q[WIDTH-2:0], 1'b0};
        else
            shifted = {1'b0, shift_q[WIDTH-1:1]};
    end

    assign shift_d = load_fire ? io.load_data : shifted;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (shift_d[i]),
            .en      (reg_en),
            .q       (shift_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_fire) begin
                state   <= SHIFT;
                bit_cnt <= CNT_FULL;
            end else if (shift_fire && (bit_cnt >= CNT_ONE)) begin
                bit_cnt <= bit_cnt - CNT_ONE;
                if (bit_cnt == CNT_ONE) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign io.load_ready = (state == IDLE);
    assign io.ser_valid  = (state == SHIFT);
    assign io.busy       = (state == SHIFT);
    assign io.done       = done_q;
    // Gated so that IDLE always presents zero, whatever the register holds.
    assign io.ser_out    = (state == SHIFT) &&
                           (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);

endmodule
